// File: rtl/phy_tx_pkg.sv
// Shared definitions for the phy_tx serial path: the K28.5 IDLE symbol, the
// transmitter state type and a width helper for occupancy counters.
package phy_tx_pkg;

  localparam logic [7:0] IDLE_K28_5 = 8'hBC;

  typedef enum logic {
    SYNC,
    ACTIVE
  } tx_state_e;

  // Width of a counter that must represent every value from 0 up to n.
  function automatic int count_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/fifo_sync.sv
// Single-clock circular-buffer FIFO. The head entry is presented on rd_data
// combinationally; pushes while full and pops while empty are ignored.
module fifo_sync
  import phy_tx_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push,
  input  logic                          pop,
  input  logic [WIDTH-1:0]              wr_data,
  output logic [WIDTH-1:0]              rd_data,
  output logic                          full,
  output logic                          empty,
  output logic [count_width(DEPTH)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = count_width(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  // NOTE: sequential state is updated with <= so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // NOTE: storage is not reset; pointers and count alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/paralelo_serie_param.sv
// Parallel-to-serial transmitter: queues words through a small FIFO and shifts
// them out one bit per clock, filling gaps and the post-reset sync with IDLE.
module paralelo_serie_param
  import phy_tx_pkg::*;
#(
  parameter int               WIDTH      = 8,
  parameter int               DEPTH      = 4,
  parameter logic [WIDTH-1:0] IDLE_SYM   = IDLE_K28_5,
  parameter int               SYNC_WORDS = 4,
  parameter bit               MSB_FIRST  = 1'b1
) (
  input  logic                          clk_8f,
  input  logic                          reset,
  input  logic [WIDTH-1:0]              data_inP,
  input  logic                          valid_in,
  output logic                          ready_out,
  output logic [WIDTH-1:0]              data2send,
  output logic                          data_outS,
  output logic                          word_start,
  output logic                          is_idle,
  output logic [count_width(DEPTH)-1:0] fifo_count
);

  localparam int               BW        = $clog2(WIDTH);
  localparam int               SCW       = count_width(SYNC_WORDS);
  localparam logic [BW-1:0]    LAST_BIT  = BW'(WIDTH - 1);
  localparam logic [SCW-1:0]   SYNC_LAST = SCW'(SYNC_WORDS);

  tx_state_e        state_q;
  tx_state_e        state_d;
  logic [BW-1:0]    bit_cnt;
  logic [BW-1:0]    bit_idx;
  logic [SCW-1:0]   sync_cnt;
  logic [SCW-1:0]   sync_cnt_d;
  logic [WIDTH-1:0] word_d;
  logic [WIDTH-1:0] head;
  logic             idle_d;
  logic             boundary;
  logic             push;
  logic             pop;
  logic             full;
  logic             empty;

  fifo_sync #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk_8f),
    .rst_n   (reset),
    .push    (push),
    .pop     (pop),
    .wr_data (data_inP),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .count   (fifo_count)
  );

  assign ready_out = !full;
  assign push      = valid_in && ready_out;
  assign boundary  = (bit_cnt == LAST_BIT);
  assign bit_idx   = MSB_FIRST ? (LAST_BIT - bit_cnt) : bit_cnt;

  // The FIFO is only consulted at a word boundary, so a word pushed on that
  // same edge waits for the following boundary.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    sync_cnt_d = sync_cnt;
    word_d     = data2send;
    idle_d     = is_idle;
    pop        = 1'b0;
    if (boundary) begin
      if (state_q == SYNC && sync_cnt != SYNC_LAST) begin
        word_d     = IDLE_SYM;
        idle_d     = 1'b1;
        sync_cnt_d = sync_cnt + 1'b1;
      end else begin
        state_d = ACTIVE;
        if (!empty) begin
          word_d = head;
          idle_d = 1'b0;
          pop    = 1'b1;
        end else begin
          word_d = IDLE_SYM;
          idle_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_8f or negedge reset) begin
    if (!reset) state_q <= SYNC;
    else        state_q <= state_d;
  end

  // The word held through reset counts as the first of the SYNC IDLEs.
  always_ff @(posedge clk_8f or negedge reset) begin
    if (!reset) begin
      sync_cnt   <= SCW'(1);
      bit_cnt    <= '0;
      data2send  <= IDLE_SYM;
      is_idle    <= 1'b1;
      data_outS  <= 1'b0;
      word_start <= 1'b0;
    end else begin
      sync_cnt   <= sync_cnt_d;
      data2send  <= word_d;
      is_idle    <= idle_d;
      data_outS  <= data2send[bit_idx];
      word_start <= (bit_cnt == '0);
      bit_cnt    <= boundary ? '0 : bit_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_paralelo_serie_param.sv
// Self-checking bench: a queue-based word-slot model predicts every output
// each cycle for an MSB-first and an LSB-first transmitter sharing stimulus.
module tb_paralelo_serie_param;

  localparam int             W    = 8;
  localparam int             D    = 4;
  localparam int             SW   = 4;
  localparam int             CW   = $clog2(D + 1);
  localparam logic [W-1:0]   IDLE = 8'hBC;

  logic           clk_8f = 1'b0;
  logic           reset;
  logic [W-1:0]   data_inP;
  logic           valid_in;
  logic           ready_out, data_outS, word_start, is_idle;
  logic [W-1:0]   data2send;
  logic [CW-1:0]  fifo_count;
  logic           l_ready, l_bit, l_ws, l_idle;
  logic [W-1:0]   l_data2send;
  logic [CW-1:0]  l_count;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: the line is a sequence of W-bit slots; slot n is loaded on edge n*W.
  logic [W-1:0] mq[$];
  logic [W-1:0] m_word;
  logic         m_idle, m_bit, m_bit_lsb, m_ws;
  int           m_edges;

  always #5 clk_8f = ~clk_8f;

  paralelo_serie_param #(
    .WIDTH(W), .DEPTH(D), .IDLE_SYM(IDLE), .SYNC_WORDS(SW), .MSB_FIRST(1'b1)
  ) dut (
    .clk_8f(clk_8f), .reset(reset), .data_inP(data_inP), .valid_in(valid_in),
    .ready_out(ready_out), .data2send(data2send), .data_outS(data_outS),
    .word_start(word_start), .is_idle(is_idle), .fifo_count(fifo_count)
  );

  paralelo_serie_param #(
    .WIDTH(W), .DEPTH(D), .IDLE_SYM(IDLE), .SYNC_WORDS(SW), .MSB_FIRST(1'b0)
  ) dut_lsb (
    .clk_8f(clk_8f), .reset(reset), .data_inP(data_inP), .valid_in(valid_in),
    .ready_out(l_ready), .data2send(l_data2send), .data_outS(l_bit),
    .word_start(l_ws), .is_idle(l_idle), .fifo_count(l_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s t=%0t observed=%h expected=%h", tag, $time, obs, exp);
    end
  endtask

  task automatic reset_model();
    mq.delete();
    m_word    = IDLE;
    m_idle    = 1'b1;
    m_edges   = 0;
    m_bit     = 1'b0;
    m_bit_lsb = 1'b0;
    m_ws      = 1'b0;
  endtask

  task automatic check_outputs();
    check("data_outS",  32'(data_outS),  32'(m_bit));
    check("word_start", 32'(word_start), 32'(m_ws));
    check("is_idle",    32'(is_idle),    32'(m_idle));
    check("data2send",  32'(data2send),  32'(m_word));
    check("fifo_count", 32'(fifo_count), mq.size());
    check("ready_out",  32'(ready_out),  32'(mq.size() < D));
    check("lsb_bit",    32'(l_bit),      32'(m_bit_lsb));
    check("lsb_ws",     32'(l_ws),       32'(m_ws));
    check("lsb_idle",   32'(l_idle),     32'(m_idle));
    check("lsb_count",  32'(l_count),    mq.size());
  endtask

  // One clock: the model advances only if reset was released before the edge.
  task automatic step();
    bit           in_rst = (reset == 1'b0);
    bit           take   = valid_in && (mq.size() < D);
    logic [W-1:0] din    = data_inP;
    @(posedge clk_8f);
    if (!in_rst) begin
      int p;
      p = m_edges % W;
      m_edges++;
      m_bit     = m_word[W-1-p];
      m_bit_lsb = m_word[p];
      m_ws      = (p == 0);
      if (p == W - 1) begin
        if ((m_edges / W) < SW || mq.size() == 0) begin
          m_word = IDLE;
          m_idle = 1'b1;
        end else begin
          m_word = mq.pop_front();
          m_idle = 1'b0;
        end
      end
      if (take) mq.push_back(din);
    end
    #1;
    check_outputs();
  endtask

  task automatic run(input int n, input int pct);
    for (int i = 0; i < n; i++) begin
      valid_in = ($urandom_range(99) < pct);
      data_inP = W'($urandom);
      step();
    end
    valid_in = 1'b0;
  endtask

  task automatic push_word(input logic [W-1:0] d);
    valid_in = 1'b1;
    data_inP = d;
    step();
    valid_in = 1'b0;
  endtask

  // Asserts reset between edges, holds it two cycles with valid_in high, releases.
  task automatic do_reset();
    reset = 1'b0;
    reset_model();
    #1;
    check_outputs();
    valid_in = 1'b1;
    data_inP = W'($urandom);
    step();
    step();
    valid_in = 1'b0;
    reset    = 1'b1;
  endtask

  initial begin
    logic [W-1:0] pat;
    reset    = 1'b1;
    valid_in = 1'b0;
    data_inP = '0;
    reset_model();
    #2;

    // Idle line after reset: only IDLE symbols, word_start every 8th cycle.
    do_reset();
    run(64, 0);

    // Single word pushed during SYNC waits for the four IDLEs.
    do_reset();
    run(1, 0);
    push_word(8'hA5);
    run(30, 0);
    check("a5_loaded", 32'(data2send), 32'h0000_00A5);
    check("a5_flag",   32'(is_idle),   32'h0);
    pat = 8'hA5;
    for (int i = 0; i < W; i++) begin
      step();
      check("a5_bit", 32'(data_outS), 32'(pat[W-1-i]));
    end
    run(2, 0);
    push_word(8'h01);
    run(40, 0);

    // Five back-to-back pushes during SYNC: the fifth is refused.
    do_reset();
    for (int i = 0; i < 5; i++) push_word(W'($urandom));
    check("full_count", 32'(fifo_count), 32'd4);
    check("full_ready", 32'(ready_out),  32'd0);
    run(80, 0);

    // Reset asserted mid-word with two words queued.
    do_reset();
    push_word(W'($urandom));
    push_word(W'($urandom));
    run(9, 0);
    check("mid_count_before", 32'(fifo_count), 32'd2);
    #2;
    do_reset();
    check("mid_bit_after",   32'(data_outS),  32'd0);
    check("mid_count_after", 32'(fifo_count), 32'd0);
    run(48, 0);

    // Sustained stream, one push per word time once ACTIVE: no IDLE gaps.
    do_reset();
    run(32, 0);
    for (int i = 0; i < 256; i++) begin
      push_word(W'(i));
      run(W - 1, 0);
      check("stream_word", 32'(data2send), i);
      check("stream_gap",  32'(is_idle),   32'd0);
    end
    run(16, 0);

    // Random traffic heavy enough to hit full with concurrent pops.
    run(600, 75);
    do_reset();
    run(400, 60);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
